// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: start/pause/clear sequencer for two cascaded BCD digit counters.
// Optional feature macro BCD_TIMER_AUTO_RELOAD_EN: reload the preset on terminal instead of DONE.
// Ports: clk, reset (async, active-low); start/pause/clear/dir_up/set_val from panel;
// u_count/t_count from counters; u_/t_ load, data, on, up to counters; busy/done/alarm status.
module bcd_timer_ctrl #(
  parameter int TICK_DIV    = 10,
  parameter int NBITS_COUNT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   pause,
  input  logic                   clear,
  input  logic                   dir_up,
  input  logic [7:0]             set_val,
  input  logic [NBITS_COUNT-1:0] u_count,
  input  logic [NBITS_COUNT-1:0] t_count,
  output logic                   u_load,
  output logic                   t_load,
  output logic [NBITS_COUNT-1:0] u_data,
  output logic [NBITS_COUNT-1:0] t_data,
  output logic                   u_on,
  output logic                   t_on,
  output logic                   u_up,
  output logic                   t_up,
  output logic                   busy,
  output logic                   done,
  output logic                   alarm
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_PAUSE, S_DONE, S_CLR
  } state_t;

  state_t state, state_nx;

  logic [PW-1:0]          psc, psc_nx;
  logic                   dir, dir_nx;
  logic [NBITS_COUNT-1:0] tgt_u, tgt_u_nx;
  logic [NBITS_COUNT-1:0] tgt_t, tgt_t_nx;
  logic [7:0]             goal;
  logic                   term;
  logic                   tick;

  function automatic logic [NBITS_COUNT-1:0] clamp9(
    input logic [NBITS_COUNT-1:0] d
  );
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign goal = dir ? {tgt_t, tgt_u} : 8'h00;
  assign term = ({t_count, u_count} == goal);
  assign tick = (psc == PS_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      psc   <= '0;
      dir   <= 1'b1;
      tgt_u <= '0;
      tgt_t <= '0;
    end else begin
      state <= state_nx;
      psc   <= psc_nx;
      dir   <= dir_nx;
      tgt_u <= tgt_u_nx;
      tgt_t <= tgt_t_nx;
    end
  end

  always_comb begin
    state_nx = state;
    psc_nx   = psc;
    dir_nx   = dir;
    tgt_u_nx = tgt_u;
    tgt_t_nx = tgt_t;
    u_load   = 1'b0;
    t_load   = 1'b0;
    u_data   = '0;
    t_data   = '0;
    u_on     = 1'b0;
    t_on     = 1'b0;
    alarm    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (clear) begin
          state_nx = S_CLR;
        end else if (start) begin
          state_nx = S_LOAD;
          dir_nx   = dir_up;
          tgt_u_nx = clamp9(set_val[3:0]);
          tgt_t_nx = clamp9(set_val[7:4]);
        end
      end
      S_LOAD: begin
        u_load   = 1'b1;
        t_load   = 1'b1;
        u_data   = dir ? '0 : tgt_u;
        t_data   = dir ? '0 : tgt_t;
        psc_nx   = '0;
        state_nx = clear ? S_CLR : S_RUN;
      end
      S_RUN: begin
        if (clear) begin
          state_nx = S_CLR;
        end else if (term) begin
          alarm = 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
          state_nx = S_LOAD;
`else
          state_nx = S_DONE;
`endif
        end else if (pause) begin
          state_nx = S_PAUSE;
        end else begin
          u_on   = tick;
          psc_nx = tick ? '0 : psc + 1'b1;
        end
      end
      S_PAUSE: begin
        if (clear) begin
          state_nx = S_CLR;
        end else if (start) begin
          state_nx = S_RUN;
        end
      end
      S_CLR: begin
        u_load   = 1'b1;
        t_load   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    // tens steps in the same cycle the units digit wraps
    t_on = u_on & (dir ? (u_count == 4'd9) : (u_count == 4'd0));
  end

  assign busy = (state == S_LOAD) || (state == S_RUN) || (state == S_PAUSE);
  assign done = (state == S_DONE);
  assign u_up = dir & busy;
  assign t_up = dir & busy;

endmodule

// File: doc/bcd_timer_ctrl.md
Name: bcd_timer_ctrl

Overview:
- Sequencing controller for two cascaded 4-bit mod-10 up/down digit counters: units and tens.
- Each counter has load / counter_on / count_up / Data_in inputs and returns its Count.
- The controller runs a prescaled tick, drives the cascade enables, detects the terminal value, and presents a start/pause/clear FSM to the user.
- Sits between front-panel button logic and the two-digit display counters.

Parameters:
- TICK_DIV, 10: clock cycles per count step (>=1; 1 = step every cycle).
- NBITS_COUNT, 4: digit width. Fixed at 4; BCD assumed.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 resets).
- start  in  1  begin a run from IDLE or DONE; resume from PAUSE.
- pause  in  1  hold the count in RUN.
- clear  in  1  abort and zero both counters.
- dir_up  in  1  1 = count 00 up to set_val; 0 = count set_val down to 00. Sampled at start.
- set_val  in  8  BCD target/preset: [7:4] tens, [3:0] units. Sampled at start.
- u_count  in  4  units counter Count.
- t_count  in  4  tens counter Count.
- u_load, t_load  out  1  counter load strobes.
- u_data, t_data  out  4  counter Data_in.
- u_on, t_on  out  1  counter_on enables.
- u_up, t_up  out  1  count_up, both equal to the latched direction.
- busy  out  1  high in LOAD, RUN, PAUSE.
- done  out  1  level, high in DONE.
- alarm  out  1  one-cycle pulse on entry to DONE.

Behaviour:
- States: IDLE, LOAD, RUN, PAUSE, DONE, CLR.
- Reset (async, reset=0):
  - state=IDLE; prescaler=0; latched dir=1; latched target=00.
  - All outputs 0.
- Input sampling and priority:
  - All inputs are sampled at the clk edge.
  - Priority: clear > start > pause.
- Digit clamping: a set_val nibble >9 is clamped to 9 when latched.
- IDLE / DONE:
  - start -> LOAD; latch dir_up and the clamped set_val.
- LOAD (exactly 1 cycle):
  - u_load=t_load=1.
  - Data = 0/0 if up, else the latched tens/units.
  - Prescaler cleared. Next state RUN.
- RUN:
  - Prescaler increments each cycle; tick when prescaler==TICK_DIV-1, then it wraps to 0.
  - u_on = tick & !term.
  - t_on = u_on & (up ? u_count==9 : u_count==0). Cascade carry/borrow is asserted in the same cycle as the units wrap.
  - term = ({t_count,u_count} == (up ? target : 8'h00)), evaluated combinationally each cycle.
  - term=1 -> DONE next edge; alarm=1 for that one cycle; no enables issued.
  - pause -> PAUSE. Prescaler value is held, and no enable is issued in the pause cycle.
- PAUSE:
  - All enables 0.
  - start -> RUN, with the prescaler continuing from its held value.
  - pause ignored.
- clear, from any state except CLR:
  - -> CLR; u_load=t_load=1 with data 0, for 1 cycle.
  - Then IDLE, with done=0.
- Boundary cases:
  - Down mode with target 00: LOAD -> RUN, term true on the first RUN cycle -> DONE with zero steps.
  - Up mode with target 00: same, DONE immediately.
  - start in RUN is ignored.
  - Simultaneous clear+start: clear wins.
- Counter reset: the counters' own reset is driven from system reset at top level, not by this block.
- Reset mid-run: everything returns to IDLE asynchronously. Pending loads/enables drop immediately.

Optional Feature:
- Macro: BCD_TIMER_AUTO_RELOAD_EN.
- Defined:
  - When term is reached in RUN, go to LOAD instead of DONE, reloading the latched preset. The run repeats indefinitely.
  - alarm still pulses for 1 cycle on each reload.
  - done never asserts.
  - pause and clear behave as normal.
- Undefined: term -> DONE as specified.

Test Plan:
- Counters: the bench instantiates two real mod-10 counters for all scenarios.
- Reset check: assert reset=0 mid-RUN -> all outputs 0 immediately. After release, state IDLE and no enables.
- Down count (TICK_DIV=2, set_val=8'h12, dir_up=0, start):
  - LOAD drives 1/2.
  - Count sequence 12,11,10,09,...,00, one step every 2 cycles.
  - t_on high exactly on the 10->09 step.
  - alarm pulses once, done=1 at 00.
- Up count with cascade (TICK_DIV=1, set_val=8'h25, dir_up=1):
  - Count 00->25 in 25 steps.
  - t_on coincides with u_count==9 on steps 09->10 and 19->20.
  - DONE reached with count 25.
- Pause/resume (TICK_DIV=3, down from 8'h05):
  - pause after 2 steps -> count frozen at 03 for 10 cycles.
  - start resumes; the next step occurs after the remaining prescaler cycles.
  - Total steps = 5.
- Clear and clamp:
  - set_val=8'hAF -> preset 99 loaded.
  - clear during RUN -> 1-cycle load of 00, then IDLE.
  - Simultaneous clear+start -> CLR taken.
- Zero target and auto-reload:
  - Down from 00 -> DONE with zero u_on pulses.
  - With BCD_TIMER_AUTO_RELOAD_EN, down from 02: sequence 02,01,00, reload 02,... with alarm on each wrap and done never high.
